// File: rtl/pb_pkg.sv
// -----------------------------------------------------------------------------
// pb_pkg
//   Shared definitions for the pushbutton conditioning stage.
//
//   Contents:
//     PB_DEBOUNCE_CYCLES_DEFAULT - default stable-cycle count
//                                  (1 ms at 50 MHz)
//     PB_SYNC_STAGES_DEFAULT     - default synchroniser depth
//     pb_pressed_level()         - raw-pin level that means "pressed"
//     pb_idle_level()            - raw-pin level that means "released"
// -----------------------------------------------------------------------------
package pb_pkg;

    localparam int PB_DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int PB_SYNC_STAGES_DEFAULT     = 2;

    // Board buttons pull the pin low when pressed. ACTIVE_LOW=0 selects
    // buttons that drive the pin high when pressed.
    function automatic logic pb_pressed_level(input int active_low);
        return (active_low != 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic pb_idle_level(input int active_low);
        return ~pb_pressed_level(active_low);
    endfunction

endpackage : pb_pkg

// File: rtl/pb_debounce_bit.sv
// -----------------------------------------------------------------------------
// pb_debounce_bit
//   One button bit: synchroniser chain, stability counter, debounced level
//   and registered press/release pulses.
//
//   Parameters:
//     SYNC_STAGES     - synchroniser flops (2..4)
//     DEBOUNCE_CYCLES - consecutive differing cycles needed to accept a
//                       change (>= 2)
//     CNT_WIDTH       - counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//     ACTIVE_LOW      - 1: pressed reads 0 on the pin; 0: pressed reads 1
//
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous reset, active-high
//     pb_raw     in   asynchronous button pin
//     pb_level   out  debounced level, raw polarity
//     pb_press   out  one-cycle pulse on an accepted press
//     pb_release out  one-cycle pulse on an accepted release
// -----------------------------------------------------------------------------
module pb_debounce_bit
    import pb_pkg::*;
#(
    parameter int SYNC_STAGES     = PB_SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_raw,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release
);

    localparam logic IDLE    = pb_idle_level(ACTIVE_LOW);
    localparam logic PRESSED = pb_pressed_level(ACTIVE_LOW);

    // Terminal count: the counter stops here and the change is accepted on
    // the edge that sees it, so it can never wrap.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser. Reset loads the idle level so that leaving reset with
    // the button released produces no spurious activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pb_raw};
        end
    end

    // Stability counter, accepted level and pulses. Any cycle where the
    // synchronised input agrees with the current level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing samples
    // moves the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            pb_level   <= IDLE;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
        end else begin
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            if (sync_out == pb_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt      <= '0;
                pb_level <= sync_out;
                if (sync_out == PRESSED) begin
                    pb_press <= 1'b1;
                end else begin
                    pb_release <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : pb_debounce_bit

// File: rtl/pb_debounce.sv
// -----------------------------------------------------------------------------
// pb_debounce
//   Conditioning stage ahead of the pushbutton PIO input port. Each button
//   bit is synchronised, debounced and turned into a clean level plus
//   single-cycle press/release pulses. An optional sticky press latch is
//   provided for edge-capture style interrupt logic.
//
//   Build option:
//     PB_DEBOUNCE_EDGE_LATCH_EN - when defined, edge_capture holds a sticky
//       flag per bit, set by pb_press and cleared by edge_clr (set wins).
//       When undefined, edge_capture is constant 0 and edge_clr is ignored.
//
//   Parameters:
//     WIDTH           - number of button bits
//     SYNC_STAGES     - synchroniser flops per bit (2..4)
//     DEBOUNCE_CYCLES - stable cycles needed to accept a change (>= 2)
//     CNT_WIDTH       - counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//     ACTIVE_LOW      - 1: pressed reads 0 on pb_raw; 0: pressed reads 1
//
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous reset, active-high
//     pb_raw       in   [WIDTH] asynchronous button pins
//     pb_level     out  [WIDTH] debounced level, raw polarity (PIO in_port)
//     pb_press     out  [WIDTH] one-cycle pulse per accepted press
//     pb_release   out  [WIDTH] one-cycle pulse per accepted release
//     edge_clr     in   [WIDTH] per-bit clear of edge_capture
//     edge_capture out  [WIDTH] sticky press flags
// -----------------------------------------------------------------------------
module pb_debounce
    import pb_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = PB_SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pb_raw,
    output logic [WIDTH-1:0] pb_level,
    output logic [WIDTH-1:0] pb_press,
    output logic [WIDTH-1:0] pb_release,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_capture
);

    // Bits are fully independent: each has its own chain and counter, so
    // simultaneous changes yield pulses on the same edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pb_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .pb_raw     (pb_raw[i]),
            .pb_level   (pb_level[i]),
            .pb_press   (pb_press[i]),
            .pb_release (pb_release[i])
        );
    end

`ifdef PB_DEBOUNCE_EDGE_LATCH_EN
    // Set has priority over clear so a press landing in the same cycle as
    // a software clear is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | pb_press;
        end
    end
`else
    logic unused_edge_clr;

    assign unused_edge_clr = ^edge_clr;
    assign edge_capture    = '0;
`endif

endmodule : pb_debounce
